// File: rtl/mdu_pkg.sv
// Shared types for the M-extension divide controller.
// XLEN is 32 when RV32 is defined, otherwise 64.
package mdu_pkg;

`ifdef RV32
    localparam int unsigned XLEN = 32;
`else
    localparam int unsigned XLEN = 64;
`endif

    localparam logic [1:0] MDU_DIV  = 2'b00;
    localparam logic [1:0] MDU_DIVU = 2'b01;
    localparam logic [1:0] MDU_REM  = 2'b10;
    localparam logic [1:0] MDU_REMU = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDrain,
        StDone
    } div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
`ifdef RV32
        return v;
`else
        return {{(XLEN-32){v[31]}}, v};
`endif
    endfunction

endpackage

// File: rtl/mdu_div_cache.sv
// One-entry result cache for the divider: stores the last completed divide's
// conditioned operands and packed {remainder, quotient}; reports a lookup hit.
module mdu_div_cache
    import mdu_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                clr_i,
    input  logic                wr_i,
    input  logic [XLEN-1:0]     wr_src1_i,
    input  logic [XLEN-1:0]     wr_src2_i,
    input  logic                wr_signed_i,
    input  logic                wr_word_i,
    input  logic [2*XLEN-1:0]   wr_data_i,
    input  logic [XLEN-1:0]     lk_src1_i,
    input  logic [XLEN-1:0]     lk_src2_i,
    input  logic                lk_signed_i,
    input  logic                lk_word_i,
    output logic                hit_o,
    output logic [2*XLEN-1:0]   data_o
);

    logic              valid_q;
    logic [XLEN-1:0]   src1_q;
    logic [XLEN-1:0]   src2_q;
    logic              signed_q;
    logic              word_q;
    logic [2*XLEN-1:0] data_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_q  <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            signed_q <= 1'b0;
            word_q   <= 1'b0;
            data_q   <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (wr_i) begin
            valid_q  <= 1'b1;
            src1_q   <= wr_src1_i;
            src2_q   <= wr_src2_i;
            signed_q <= wr_signed_i;
            word_q   <= wr_word_i;
            data_q   <= wr_data_i;
        end
    end

    assign hit_o  = valid_q && (src1_q == lk_src1_i) && (src2_q == lk_src2_i) &&
                    (signed_q == lk_signed_i) && (word_q == lk_word_i);
    assign data_o = data_q;

endmodule

// File: rtl/mdu_div_ctrl.sv
// Issue/writeback controller around the iterative divider. Macros: RV32 selects
// XLEN=32; MDU_DIV_CACHE_EN adds a one-entry result cache (mdu_div_cache).
module mdu_div_ctrl
    import mdu_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                req_i,
    input  logic                flush_i,
    input  logic [1:0]          op_i,
    input  logic                word_i,
    input  logic [XLEN-1:0]     src1_i,
    input  logic [XLEN-1:0]     src2_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [XLEN-1:0]     rd_data_o,
    output logic                div_trig_o,
    output logic                div_flush_o,
    output logic                div_signed1_o,
    output logic                div_signed2_o,
    output logic [XLEN-1:0]     div_src1_o,
    output logic [XLEN-1:0]     div_src2_o,
    input  logic [2*XLEN-1:0]   div_out_i,
    input  logic                div_okay_i
);

    div_state_e        state_q;
    logic              rem_q;
    logic              word_q;
    logic              signed_q;
    logic [XLEN-1:0]   src1_q;
    logic [XLEN-1:0]   src2_q;
    logic [XLEN-1:0]   rd_data_q;

    logic              sgn_in;
    logic              word_in;
    logic [XLEN-1:0]   src1_c;
    logic [XLEN-1:0]   src2_c;
    logic              hit;
    logic [2*XLEN-1:0] cache_data;

    function automatic logic [XLEN-1:0] pick(input logic [2*XLEN-1:0] d, input logic rem,
                                              input logic word);
        logic [XLEN-1:0] half;
        half = rem ? d[2*XLEN-1:XLEN] : d[XLEN-1:0];
        return word ? sext32(half[31:0]) : half;
    endfunction

    always_comb begin
        sgn_in  = ~op_i[0];
        word_in = 1'b0;
        src1_c  = src1_i;
        src2_c  = src2_i;
`ifndef RV32
        word_in = word_i;
        if (word_i) begin
            src1_c = sgn_in ? sext32(src1_i[31:0]) : {32'b0, src1_i[31:0]};
            src2_c = sgn_in ? sext32(src2_i[31:0]) : {32'b0, src2_i[31:0]};
        end
`endif
    end

`ifdef MDU_DIV_CACHE_EN
    logic cache_wr;
    logic cache_clr;

    assign cache_wr  = (state_q == StWait) && div_okay_i && !flush_i;
    // Leaving for DRAIN: the in-flight result is abandoned, so drop the entry.
    assign cache_clr = (state_q == StWait) && flush_i && !div_okay_i;

    mdu_div_cache u_cache (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clr_i       (cache_clr),
        .wr_i        (cache_wr),
        .wr_src1_i   (src1_q),
        .wr_src2_i   (src2_q),
        .wr_signed_i (signed_q),
        .wr_word_i   (word_q),
        .wr_data_i   (div_out_i),
        .lk_src1_i   (src1_c),
        .lk_src2_i   (src2_c),
        .lk_signed_i (sgn_in),
        .lk_word_i   (word_in),
        .hit_o       (hit),
        .data_o      (cache_data)
    );
`else
    assign hit        = 1'b0;
    assign cache_data = '0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= StIdle;
            rem_q     <= 1'b0;
            word_q    <= 1'b0;
            signed_q  <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
            rd_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_i && !flush_i) begin
                        rem_q    <= op_i[1];
                        word_q   <= word_in;
                        signed_q <= sgn_in;
                        src1_q   <= src1_c;
                        src2_q   <= src2_c;
                        if (hit) begin
                            rd_data_q <= pick(cache_data, op_i[1], word_in);
                            state_q   <= StDone;
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: state_q <= flush_i ? StIdle : StWait;
                StWait: begin
                    if (flush_i) begin
                        state_q <= div_okay_i ? StIdle : StDrain;
                    end else if (div_okay_i) begin
                        rd_data_q <= pick(div_out_i, rem_q, word_q);
                        state_q   <= StDone;
                    end
                end
                StDrain: if (div_okay_i) state_q <= StIdle;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone) && !flush_i;
    assign div_trig_o    = (state_q == StIssue) && !flush_i;
    assign div_flush_o   = (state_q == StWait) && flush_i;
    assign rd_data_o     = rd_data_q;
    assign div_signed1_o = signed_q;
    assign div_signed2_o = signed_q;
    assign div_src1_o    = src1_q;
    assign div_src2_o    = src2_q;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Scoreboard bench for mdu_div_ctrl (RV64 build) with a behavioural divider stand-in.
module tb_mdu_div_ctrl;
    import mdu_pkg::*;

`ifdef MDU_DIV_CACHE_EN
    localparam bit CacheEn = 1'b1;
`else
    localparam bit CacheEn = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int checks, errors, cyc, trig_cnt, flush_cnt, lat_m, m_cnt;

    logic         clk, rstn, req, flush, word;
    logic [1:0]   op;
    logic [63:0]  src1, src2;
    logic         busy, done, trig, dflush, sg1, sg2, div_okay;
    logic [63:0]  rd_data, dsrc1, dsrc2;
    logic [127:0] div_out;

    mdu_div_ctrl dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .req_i         (req),
        .flush_i       (flush),
        .op_i          (op),
        .word_i        (word),
        .src1_i        (src1),
        .src2_i        (src2),
        .busy_o        (busy),
        .done_o        (done),
        .rd_data_o     (rd_data),
        .div_trig_o    (trig),
        .div_flush_o   (dflush),
        .div_signed1_o (sg1),
        .div_signed2_o (sg2),
        .div_src1_o    (dsrc1),
        .div_src2_o    (dsrc2),
        .div_out_i     (div_out),
        .div_okay_i    (div_okay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RISC-V divide semantics, including x/0 and MIN/-1.
    function automatic logic [127:0] div_model(input logic [63:0] a, input logic [63:0] b,
                                               input logic sg);
        logic [63:0] q, r;
        if (b == 64'd0) begin
            q = '1;
            r = a;
        end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a;
            r = 64'd0;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider stand-in: okay pulses lat_m cycles after the trig cycle; flush does not abort.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt   <= 0;
            div_out <= '0;
        end else if (trig) begin
            m_cnt   <= lat_m;
            div_out <= div_model(dsrc1, dsrc2, sg1);
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign div_okay = (m_cnt == 1);

    always @(negedge clk) begin
        if (trig) trig_cnt++;
        if (dflush) flush_cnt++;
        if (done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done with rd_data %h, required no done", rd_data);
            end else begin
                mon_e = sb_q.pop_front();
                if (rd_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL rd_data: got %h, required %h", rd_data, mon_e.data);
                end
                checks++;
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d, required %0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input logic [63:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    // Entered at a negedge; returns one posedge+1 into the first idle cycle after that.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy got 1 after 100 cycles, required 0", name);
        end
        tick();
    endtask

    task automatic issue(input string name, input logic [1:0] o, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input int lat,
                         input bit hit, input logic [63:0] exp_s1, input logic [63:0] exp_v);
        int t0, tr0;
        lat_m = lat;
        tr0   = trig_cnt;
        req   = 1'b1;
        op    = o;
        word  = w;
        src1  = a;
        src2  = b;
        t0    = cyc;
        expect_done(exp_v, hit ? t0 + 1 : t0 + lat + 2);
        tick();
        req = 1'b0;
        @(negedge clk);
        chk({name, "_busy"}, 64'(busy), 64'd1);
        chk({name, "_src1"}, dsrc1, exp_s1);
        wait_idle(name);
        chk({name, "_trig"}, 64'(trig_cnt - tr0), hit ? 64'd0 : 64'd1);
    endtask

    initial begin
        int t0, f0;
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, f0;
        rstn = 1'b0; req = 1'b0; flush = 1'b0; word = 1'b0; op = 2'b00;
        src1 = '0; src2 = '0; lat_m = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_trig", 64'(trig), 64'd0);
        chk("rst_flush", 64'(dflush), 64'd0);
        chk("rst_signed1", 64'(sg1), 64'd0);
        chk("rst_signed2", 64'(sg2), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_src1", dsrc1, 64'd0);
        chk("rst_src2", dsrc2, 64'd0);
        rstn = 1'b1;
        tick();

        issue("div_neg", MDU_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5, 1'b0,
              64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFFA);
        issue("rem_neg", MDU_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5, CacheEn,
              64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFFE);
        issue("divu_zero", MDU_DIVU, 1'b0, 64'd7, 64'd0, 1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        issue("remu_zero", MDU_REMU, 1'b0, 64'd7, 64'd0, 1, CacheEn, 64'd7, 64'd7);
        issue("divw_ovf", MDU_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3,
              1'b0, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000);
        issue("remuw", MDU_REMU, 1'b1, 64'hABCD_1234_FFFF_FFFF, 64'h5555_0000_0000_0010, 4,
              1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_000F);

        // Flush two cycles into WAIT on a long divide.
        lat_m = 10;
        f0    = flush_cnt;
        req = 1'b1; op = MDU_DIV; word = 1'b0; src1 = 64'd100; src2 = 64'd7;
        t0  = cyc;
        tick(); req = 1'b0;
        repeat (3) tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_pulse", 64'(dflush), 64'd1);
        tick(); flush = 1'b0;
        while (cyc < t0 + 11) tick();
        @(negedge clk);
        chk("drain_busy_at_okay", 64'(busy), 64'd1);
        tick();
        @(negedge clk);
        chk("drain_busy_after_okay", 64'(busy), 64'd0);
        chk("flush_pulse_count", 64'(flush_cnt - f0), 64'd1);
        tick();
        issue("div_after_flush", MDU_DIV, 1'b0, 64'd100, 64'd7, 2, 1'b0, 64'd100, 64'd14);

        // req together with flush in idle is dropped.
        req = 1'b1; flush = 1'b1; op = MDU_DIVU; word = 1'b0; src1 = 64'd9; src2 = 64'd2;
        tick(); req = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("req_flush_busy", 64'(busy), 64'd0);
        tick();

        // req held through the whole op: second accept only in the idle cycle after done.
        lat_m = 2;
        req = 1'b1; op = MDU_DIVU; word = 1'b0; src1 = 64'd9; src2 = 64'd2;
        t0  = cyc;
        expect_done(64'd4, t0 + 4);
        expect_done(64'd4, CacheEn ? t0 + 6 : t0 + 9);
        repeat (6) tick();
        req = 1'b0;
        @(negedge clk);
        wait_idle("held_req");

        // Reset in the middle of WAIT, then a previously completed op must re-issue.
        lat_m = 20;
        req = 1'b1; op = MDU_DIV; word = 1'b0; src1 = 64'd100; src2 = 64'd7;
        tick(); req = 1'b0;
        repeat (3) tick();
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_trig", 64'(trig), 64'd0);
        chk("mid_rst_rd_data", rd_data, 64'd0);
        chk("mid_rst_src1", dsrc1, 64'd0);
        chk("mid_rst_src2", dsrc2, 64'd0);
        chk("mid_rst_signed1", 64'(sg1), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        issue("post_reset_divu", MDU_DIVU, 1'b0, 64'd9, 64'd2, 1, 1'b0, 64'd9, 64'd4);

        repeat (3) tick();
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_div_ctrl.md
# mdu_div_ctrl

Issue and writeback controller for the iterative divider in the M-extension unit. It accepts DIV/DIVU/REM/REMU (and W variants on RV64) from the execute stage, conditions operands and drives the divider's trig/flush/src interface. It consumes the divider's packed {remainder, quotient} result, selects and sign-extends the requested half, and returns it with a one-cycle done pulse. The divider is a sibling instance; this block owns all sequencing around it.

## Interface
- XLEN: 32 under RV32, else 64. Macro-derived, not a parameter.
- clk  in  1  core clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- req  in  1  execute stage presents a divide op; sampled only in IDLE
- flush  in  1  pipeline kill
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- word  in  1  W-variant; ignored under RV32
- src1, src2  in  XLEN  rs1, rs2
- busy  out  1  stall request; high whenever state != IDLE
- done  out  1  one-cycle result-valid pulse
- rd_data  out  XLEN  result; registered, held until next done
- div_trig, div_flush, div_signed1, div_signed2  out  1  to divider
- div_src1, div_src2  out  XLEN  to divider; always driven from registers
- div_out  in  2*XLEN  divider result: [XLEN-1:0] quotient, [2*XLEN-1:XLEN] remainder
- div_okay  in  1  divider completion pulse

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE: req & ~flush latches op, word, signedness (op[0]==0) and conditioned operands.
  - Goes to DONE on a cache hit, otherwise to ISSUE.
  - req & flush is dropped.
- Operand conditioning, word=1 on RV64:
  - Signed ops sign-extend src[31:0]; unsigned ops zero-extend.
  - XLEN ops pass through.
- div_src1/div_src2/div_signed* hold the latched values from accept until the return to IDLE. The divider re-evaluates its skip path every cycle, so these inputs must never change mid-operation.
- ISSUE: div_trig=1 for exactly this cycle, then WAIT.
  - Flush in ISSUE suppresses div_trig and returns to IDLE.
- WAIT: waits for div_okay.
  - On div_okay: latch the result half (quotient for op[1]==0, remainder otherwise) into rd_data.
  - If word, rd_data = sext(half[31:0]).
  - Then go to DONE.
- Flush in WAIT: div_flush=1 that cycle.
  - If div_okay is in the same cycle, discard the result and go to IDLE.
  - Otherwise go to DRAIN.
- DRAIN: wait for div_okay, discard the result, go to IDLE. Flush is ignored here.
- DONE: done=1, go to IDLE.
  - Flush in DONE suppresses done; rd_data still updates.
- Div-by-zero and signed overflow are resolved by the divider; no special-casing here.
  - x/0 gives quotient all-ones and remainder x.
  - MIN/-1 gives quotient MIN and remainder 0.
- Reset values: state IDLE; busy, done, div_trig, div_flush, div_signed* = 0; rd_data, div_src* = 0.

## Timing
- Accept at cycle T.
  - Cycles T+1..: busy=1.
  - T+1: div_trig.
  - Divider skip path: div_okay at T+2, done at T+3.
  - Full iteration: done = div_okay + 1.
  - Cache hit: done at T+1, no div_trig.
- A new req can be accepted in the cycle after done (IDLE).
- div_flush is combinational from flush & (state==WAIT).

## Configuration
- MDU_DIV_CACHE_EN defined: a one-entry cache holds {valid, src1, src2, signed, word, div_out} for the last completed divide.
  - It is written on div_okay in WAIT without flush.
  - A request whose conditioned operands, signedness and word all match returns from the cached div_out. This covers the DIV-then-REM idiom.
  - Reset and DRAIN entry clear valid.
- Undefined: no cache storage; every request issues to the divider.

## Structure
- Package mdu_pkg: op encodings (MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU) and the state enum.
- Optional sub-module mdu_div_cache (entry storage plus match compare), instantiated only under MDU_DIV_CACHE_EN.

## Test plan
- DIV -20/3, RV64: done at divider okay+1, rd_data = -6. Then REM with the same operands: rd_data = -2. With the cache enabled, done at T+1 and no div_trig.
- DIVU 7/0: rd_data = all-ones. REMU 7/0: rd_data = 7. Both with done at T+3.
- DIVW 0x80000000/-1, RV64: rd_data = 0xFFFFFFFF80000000. REMUW 0xFFFFFFFF/0x10 with upper bits set in src1: rd_data = 0xF.
- Flush two cycles into WAIT on a long divide: div_flush pulses once, no done, busy drops the cycle after div_okay. A following req completes correctly.
- req & flush in the same IDLE cycle: no accept, busy stays 0. Then req held during busy: accepted only after done.
- Reset asserted mid-WAIT: all outputs return to reset values, cache invalid, next req fully re-issued.
